// File: rtl/dpram_fifo_ctrl_if.sv
// Stream-side bundle of the DPRAM FIFO controller: write handshake, read handshake and fill count.
// The FIFO is the slave; the user logic that pushes and pops is the master.
interface dpram_fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
);
  localparam int CW = $clog2(DEPTH + 3);

  logic [WIDTH-1:0] InData;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] OutData;
  logic             OutValid;
  logic             OutReady;
  logic [CW-1:0]    Count;

  modport master (
    output InData, InValid, OutReady,
    input  InReady, OutData, OutValid, Count
  );

  modport slave (
    input  InData, InValid, OutReady,
    output InReady, OutData, OutValid, Count
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external dual-port RAM with 1-cycle read
// latency; a 2-entry output stage (head + skid) hides that latency for one word per clock.
module dpram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
) (
  input  logic                       Clock,
  input  logic                       Reset,
  dpram_fifo_ctrl_if.slave           bus,
  output logic [$clog2(DEPTH)-1:0]   RamWrAddress,
  output logic                       RamWE,
  output logic [WIDTH-1:0]           RamData,
  output logic [$clog2(DEPTH)-1:0]   RamRdAddress,
  input  logic [WIDTH-1:0]           RamQ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 3);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [1:0]       stage_occ_q, stage_occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic       in_ready;
  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] occ_after_pop;

  always_comb begin
    in_ready      = !Reset && (ram_cnt_q < DEPTH_C);
    push          = bus.InValid && in_ready;
    pop           = (stage_occ_q != 2'd0) && bus.OutReady;
    occ_after_pop = stage_occ_q - {1'b0, pop};
    // A read is only launched when the stage is guaranteed a free slot for its data.
    issue         = (ram_cnt_q != '0) && ((occ_after_pop + {1'b0, rd_pend_q}) < 2'd2);

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (issue) begin
      rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + AW'(1);
    end

    ram_cnt_d = ram_cnt_q + CW'(push) - CW'(issue);
    rd_pend_d = issue;

    head_d = head_q;
    skid_d = skid_q;
    if (pop && (stage_occ_q == 2'd2)) begin
      head_d = skid_q;
    end
    // Returning read data lands in the first free slot after this cycle's pop.
    if (rd_pend_q) begin
      if (occ_after_pop == 2'd0) begin
        head_d = RamQ;
      end else begin
        skid_d = RamQ;
      end
    end
    stage_occ_d = occ_after_pop + {1'b0, rd_pend_q};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      stage_occ_q <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      rd_pend_q   <= rd_pend_d;
      stage_occ_q <= stage_occ_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = (stage_occ_q != 2'd0);
  assign bus.OutData  = head_q;
  assign bus.Count    = ram_cnt_q + CW'(rd_pend_q) + CW'(stage_occ_q);

  assign RamWE        = push;
  assign RamWrAddress = wr_ptr_q;
  assign RamData      = bus.InData;
  assign RamRdAddress = rd_ptr_q;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural registered-read RAM and a queue scoreboard.
module tb_dpram_fifo_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [AW-1:0]    ram_wa, ram_ra;
  logic             ram_we;
  logic [WIDTH-1:0] ram_d, ram_q;
  logic [WIDTH-1:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] sb [$];

  logic             s_irdy, s_ovld, s_we;
  logic [WIDTH-1:0] s_od;
  logic [CW-1:0]    s_cnt;
  logic [AW-1:0]    s_wa;

  dpram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dpram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .bus          (bus),
    .RamWrAddress (ram_wa),
    .RamWE        (ram_we),
    .RamData      (ram_d),
    .RamRdAddress (ram_ra),
    .RamQ         (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_d;
    ram_q <= mem[ram_ra];
  end

  // Drive one cycle's inputs, sample outputs before the edge, then step past the edge.
  task automatic cyc(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    bus.InValid  = iv;
    bus.InData   = id;
    bus.OutReady = ordy;
    #1;
    s_irdy = bus.InReady;
    s_ovld = bus.OutValid;
    s_od   = bus.OutData;
    s_cnt  = bus.Count;
    s_we   = ram_we;
    s_wa   = ram_wa;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 8'h11, 1'b0);
      total++;
      if (s_irdy !== 1'b0) begin
        bad++; $display("FAIL reset_inready: got %b want 0", s_irdy);
      end
    end
    rst = 1'b0;
    bus.InValid = 1'b0;
    #1;
    total++;
    if (bus.OutValid !== 1'b0) begin
      bad++; $display("FAIL reset_outvalid: got %b want 0", bus.OutValid);
    end
    total++;
    if (bus.Count !== 4'd0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", bus.Count);
    end
    total++;
    if (bus.OutData !== 8'h00) begin
      bad++; $display("FAIL reset_outdata: got %h want 00", bus.OutData);
    end
    total++;
    if (bus.InReady !== 1'b1) begin
      bad++; $display("FAIL reset_release_inready: got %b want 1", bus.InReady);
    end
    @(posedge clk); #1;
    $display("test_reset complete");
  endtask

  task automatic test_latency();
    cyc(1'b1, 8'hA5, 1'b0);
    total++;
    if (s_irdy !== 1'b1) begin
      bad++; $display("FAIL lat_accept: got inready=%b want 1", s_irdy);
    end
    cyc(1'b0, '0, 1'b0);
    total++;
    if (s_ovld !== 1'b0 || s_cnt !== 4'd1) begin
      bad++; $display("FAIL lat_after_e0: got valid=%b count=%0d want 0/1", s_ovld, s_cnt);
    end
    cyc(1'b0, '0, 1'b0);
    total++;
    if (s_ovld !== 1'b0) begin
      bad++; $display("FAIL lat_after_e1: got valid=%b want 0", s_ovld);
    end
    cyc(1'b0, '0, 1'b1);
    total++;
    if (s_ovld !== 1'b1 || s_od !== 8'hA5 || s_cnt !== 4'd1) begin
      bad++; $display("FAIL lat_after_e2: got valid=%b data=%h count=%0d want 1/a5/1", s_ovld, s_od, s_cnt);
    end
    bus.OutReady = 1'b0;
    #1;
    total++;
    if (bus.OutValid !== 1'b0 || bus.Count !== 4'd0) begin
      bad++; $display("FAIL lat_pop: got valid=%b count=%0d want 0/0", bus.OutValid, bus.Count);
    end
    $display("test_latency complete");
  endtask

  task automatic test_fill_drain();
    int acc;
    int got;
    logic [WIDTH-1:0] exp;
    acc = 0;
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (s_irdy) begin
        acc++;
        sb.push_back(8'(i));
      end
    end
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    total++;
    if (acc != 12) begin
      bad++; $display("FAIL fill_accepted: got %0d want 12", acc);
    end
    total++;
    if (s_cnt !== 4'd12 || s_irdy !== 1'b0) begin
      bad++; $display("FAIL fill_full: got count=%0d inready=%b want 12/0", s_cnt, s_irdy);
    end
    got = 0;
    for (int c = 0; c < 30 && got < 12; c++) begin
      cyc(1'b0, '0, 1'b1);
      if (s_ovld) begin
        total++;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        if (s_od !== exp || got !== int'(exp)) begin
          bad++; $display("FAIL drain_data: got %h want %h (index %0d)", s_od, exp, got);
        end
        got++;
      end
    end
    total++;
    if (got != 12 || bus.Count !== 4'd0 || bus.OutValid !== 1'b0) begin
      bad++; $display("FAIL drain_end: got words=%0d count=%0d valid=%b want 12/0/0", got, bus.Count, bus.OutValid);
    end
    $display("test_fill_drain complete: accepted=%0d drained=%0d", acc, got);
  endtask

  task automatic test_stream();
    int pushed, popped, first, last, wraps;
    logic [WIDTH-1:0] exp;
    do_reset();
    pushed = 0; popped = 0; first = -1; last = -1; wraps = 0;
    for (int c = 0; c < 120 && popped < 40; c++) begin
      cyc(pushed < 40, 8'(pushed), 1'b1);
      if (pushed < 40 && s_irdy) begin
        total++;
        if (s_we !== 1'b1) begin
          bad++; $display("FAIL stream_we: got %b want 1", s_we);
        end
        if (s_wa == 4'd9) wraps++;
        sb.push_back(8'(pushed));
        pushed++;
      end
      if (s_ovld) begin
        total++;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        if (s_od !== exp) begin
          bad++; $display("FAIL stream_data: got %h want %h", s_od, exp);
        end
        if (first < 0) first = c;
        last = c;
        popped++;
      end
    end
    total++;
    if (first != 3) begin
      bad++; $display("FAIL stream_first_pop: got cycle %0d want 3", first);
    end
    total++;
    if (popped != 40 || (last - first) != 39) begin
      bad++; $display("FAIL stream_gapless: got pops=%0d span=%0d want 40/39", popped, last - first);
    end
    total++;
    if (wraps != 4) begin
      bad++; $display("FAIL stream_wraps: got %0d want 4", wraps);
    end
    $display("test_stream complete: pops=%0d first=%0d last=%0d", popped, first, last);
  endtask

  task automatic test_random();
    int pushed, popped;
    logic iv, ordy, prev_stall;
    logic [WIDTH-1:0] din, prev_od, exp;
    do_reset();
    pushed = 0; popped = 0; prev_stall = 1'b0; prev_od = '0;
    for (int c = 0; c < 6000 && popped < 500; c++) begin
      iv   = (pushed < 500) && ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 1) == 1);
      din  = 8'($urandom);
      cyc(iv, din, ordy);
      total++;
      if (s_cnt !== 4'(sb.size())) begin
        bad++; $display("FAIL rand_count: got %0d want %0d", s_cnt, sb.size());
      end
      total++;
      if (s_cnt > 4'd12) begin
        bad++; $display("FAIL rand_count_max: got %0d want <=12", s_cnt);
      end
      if (prev_stall) begin
        total++;
        if (s_ovld !== 1'b1 || s_od !== prev_od) begin
          bad++; $display("FAIL rand_stall_hold: got valid=%b data=%h want 1/%h", s_ovld, s_od, prev_od);
        end
      end
      prev_stall = s_ovld && !ordy;
      prev_od    = s_od;
      if (s_ovld && ordy) begin
        total++;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        if (s_od !== exp) begin
          bad++; $display("FAIL rand_data: got %h want %h", s_od, exp);
        end
        popped++;
      end
      if (iv && s_irdy) begin
        sb.push_back(din);
        pushed++;
      end
    end
    total++;
    if (popped != 500) begin
      bad++; $display("FAIL rand_complete: got %0d words want 500", popped);
    end
    $display("test_random complete: pushed=%0d popped=%0d", pushed, popped);
  endtask

  task automatic test_full_simul();
    int k, first_rdy;
    logic [WIDTH-1:0] exp;
    do_reset();
    k = 100;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, 8'(k), 1'b0);
      if (s_irdy) begin
        sb.push_back(8'(k));
        k++;
      end
    end
    cyc(1'b0, '0, 1'b0);
    total++;
    if (s_cnt !== 4'd12 || s_irdy !== 1'b0) begin
      bad++; $display("FAIL full_level: got count=%0d inready=%b want 12/0", s_cnt, s_irdy);
    end
    first_rdy = -1;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b1, 8'(k), 1'b1);
      if (c == 0) begin
        total++;
        if (s_irdy !== 1'b0) begin
          bad++; $display("FAIL full_simul_refuse: got inready=%b want 0", s_irdy);
        end
      end
      if (s_ovld) begin
        total++;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        if (s_od !== exp) begin
          bad++; $display("FAIL full_simul_data: got %h want %h", s_od, exp);
        end
      end
      if (s_irdy) begin
        if (first_rdy < 0) first_rdy = c;
        sb.push_back(8'(k));
        k++;
      end
    end
    total++;
    if (first_rdy < 1 || first_rdy > 2) begin
      bad++; $display("FAIL full_simul_ready_return: got cycle %0d want 1..2", first_rdy);
    end
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      cyc(1'b0, '0, 1'b1);
      if (s_ovld) begin
        total++;
        exp = sb.pop_front();
        if (s_od !== exp) begin
          bad++; $display("FAIL full_drain_data: got %h want %h", s_od, exp);
        end
      end
    end
    total++;
    if (sb.size() != 0 || bus.Count !== 4'd0 || bus.OutValid !== 1'b0) begin
      bad++; $display("FAIL full_drain_end: got left=%0d count=%0d valid=%b want 0/0/0", sb.size(), bus.Count, bus.OutValid);
    end
    $display("test_full_simul complete: words=%0d", k - 100);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 8'(8'h50 + i), 1'b0);
    end
    cyc(1'b0, '0, 1'b0);
    total++;
    if (s_cnt !== 4'd7) begin
      bad++; $display("FAIL mid_count_before: got %0d want 7", s_cnt);
    end
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
    #1;
    total++;
    if (bus.Count !== 4'd0 || bus.OutValid !== 1'b0 || bus.OutData !== 8'h00) begin
      bad++; $display("FAIL mid_reset_state: got count=%0d valid=%b data=%h want 0/0/00", bus.Count, bus.OutValid, bus.OutData);
    end
    @(posedge clk); #1;
    cyc(1'b1, 8'h3C, 1'b0);
    total++;
    if (s_irdy !== 1'b1) begin
      bad++; $display("FAIL mid_push_accept: got inready=%b want 1", s_irdy);
    end
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    total++;
    if (s_ovld !== 1'b1 || s_od !== 8'h3C) begin
      bad++; $display("FAIL mid_first_word: got valid=%b data=%h want 1/3c", s_ovld, s_od);
    end
    bus.OutReady = 1'b0;
    #1;
    total++;
    if (bus.Count !== 4'd0 || bus.OutValid !== 1'b0) begin
      bad++; $display("FAIL mid_empty_after: got count=%0d valid=%b want 0/0", bus.Count, bus.OutValid);
    end
    $display("test_reset_mid complete");
  endtask

  initial begin
    bus.InValid  = 1'b0;
    bus.InData   = '0;
    bus.OutReady = 1'b0;
    test_reset();
    test_latency();
    test_fill_drain();
    test_stream();
    test_random();
    test_full_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives the write and read ports of the team's inferred dual-port RAM (both RAM clocks tied to Clock). It consumes the RAM's registered read data (1-cycle read latency). It presents a first-word-fall-through valid/ready stream on both sides. A 2-entry output stage hides the RAM read latency, so the FIFO sustains one word per clock in steady state.

Parameters:
WIDTH, 8, data word width in bits.
DEPTH, 10, RAM entries (any value >= 2; power of 2 not required); RAM address width AW = $clog2(DEPTH).
CW, $clog2(DEPTH+3), Count width (total capacity DEPTH+2).

Ports:
Clock  input  1  single clock; also wired to the RAM's WrClock and RdClock.
Reset  input  1  synchronous, active-high.
InData  input  WIDTH  write-side data.
InValid  input  1  write-side valid.
InReady  output  1  write-side ready.
OutData  output  WIDTH  head word (registered).
OutValid  output  1  head word valid (registered).
OutReady  input  1  read-side ready.
Count  output  CW  total words held (RAM + in-flight read + output stage).
RamWrAddress  output  AW  to RAM WrAddress.
RamWE  output  1  to RAM WE.
RamData  output  WIDTH  to RAM Data.
RamRdAddress  output  AW  to RAM RdAddress.
RamQ  input  WIDTH  from RAM Q; valid the cycle after the read is issued.

Behaviour:
- State: wr_ptr, rd_ptr (AW bits); ram_cnt (0..DEPTH); rd_pend (1 bit); 2-entry output stage (head = OutData, skid); stage_occ (0..2).
- Reset (synchronous): pointers, ram_cnt, rd_pend and stage_occ go to 0. OutValid=0, OutData=0, Count=0. InReady=0 while Reset is high. RAM contents are not cleared and are never read before being rewritten.
- InReady = !Reset && ram_cnt < DEPTH; push = InValid && InReady.
- RamWE = push; RamWrAddress = wr_ptr; RamData = InData (all combinational). On push, wr_ptr advances, wrapping DEPTH-1 -> 0.
- pop = OutValid && OutReady. OutValid = (stage_occ != 0).
- RamRdAddress = rd_ptr at all times. The RAM reads every cycle; RamQ is used only when rd_pend=1.
- issue = ram_cnt != 0 && (stage_occ - pop + rd_pend) < 2. On issue, rd_ptr advances (wrapping DEPTH-1 -> 0) and rd_pend <= 1 next cycle; otherwise rd_pend <= 0.
- ram_cnt next = ram_cnt + push - issue.
- When rd_pend=1, RamQ is captured into the stage in FIFO order: into head if the stage is empty or the head is popping with an empty skid, otherwise into skid. On pop with skid occupied, skid moves to head. Stage ordering is strictly preserved.
- The issue rule guarantees the stage never overflows. No data is captured when rd_pend=0.
- Count = ram_cnt + rd_pend + stage_occ (registered terms only).
- Latency: for a word accepted at clock edge E0 into an empty FIFO, the read is issued in the next cycle and RamQ is valid after E1. OutValid=1 after E2, i.e. 2 clocks.
- Throughput: with InValid=1 and OutReady=1, one push and one pop per cycle after the initial fill.
- Hazard: a read never targets the address written in the same cycle. A read needs ram_cnt>0, and rd_ptr==wr_ptr with ram_cnt>0 implies the FIFO is full, so InReady=0. RAM read-during-write semantics are therefore irrelevant.
- Full: ram_cnt==DEPTH -> InReady=0; with OutReady=0 the maximum is Count=DEPTH+2. Empty: Count=0, OutValid=0.
- Simultaneous push and pop at full: push is refused that cycle (InReady is based on the registered ram_cnt). InReady rises the cycle after an issue frees a RAM slot.
- OutData holds its value while OutValid=1 && OutReady=0.
- Reset mid-operation: all words are discarded; the next cycle behaves as post-reset.

Test Plan:
1. Reset, then push 0xA5 once with OutReady=0 -> OutValid=1 exactly 2 clocks after the accept edge; OutData=0xA5; Count=1; pop -> Count=0, OutValid=0.
2. DEPTH=10, OutReady=0, push 0..15 continuously -> exactly 12 accepted (0..11); InReady=0 thereafter; Count=12; then drain -> outputs 0..11 in order.
3. Continuous InValid=1, OutReady=1, 40 incrementing words -> after 2-cycle fill, one pop per cycle, no gaps, order preserved; pointers wrap 9->0 four times.
4. Random InValid/OutReady (50% each), 500 words -> scoreboard order match; Count never exceeds 12; OutData stable while stalled.
5. Fill to Count=12, then OutReady=1 and InValid=1 together -> first cycle push refused, InReady returns within 2 cycles, stream continues without loss or duplication.
6. Assert Reset for 1 cycle with Count=7 mid-stream -> next cycle Count=0, OutValid=0, OutData=0; a new push 0x3C emerges as the first word out.
